// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the axis_int_divider core
package div_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DIV_ITERS = 32;
  localparam int DIV_LATENCY = 34;
  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring radix-2 division iteration
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvs,
  input  logic         nb,
  output logic [W-1:0] rem_n,
  output logic         qb
);
  logic [W:0] sh, diff;
  assign sh = {rem, nb};
  assign diff = sh - {1'b0, dvs};
  assign qb = ~diff[W];
  assign rem_n = qb ? diff[W-1:0] : sh[W-1:0];
endmodule

// File: rtl/axis_int_divider.sv
// axis_int_divider: iterative signed divider, fixed latency; DIVIDER_DBZ_FLAG_EN adds m_axis_dout_tuser
module axis_int_divider
  import div_pkg::*;
#(
  parameter int DATA_W = div_pkg::DATA_W
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_dividend_tvalid,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_divisor_tvalid,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                  m_axis_dout_tuser
`endif
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] dvd, dvs, rem, raw, rem_n, abs_a, abs_b, q_fix, r_fix;
  logic qb, qneg, rneg, dbz, dbz_out, accept;
  logic [DATA_W-1:0] a, b;
  assign a = s_axis_dividend_tdata;
  assign b = s_axis_divisor_tdata;
  assign accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign abs_a = a[DATA_W-1] ? -a : a;
  assign abs_b = b[DATA_W-1] ? -b : b;
  assign q_fix = dbz ? '1 : qneg ? -dvd : dvd;
  assign r_fix = dbz ? raw : rneg ? -rem : rem;
  div_step #(.W(DATA_W)) u_step (
    .rem  (rem),
    .dvs  (dvs),
    .nb   (dvd[DATA_W-1]),
    .rem_n(rem_n),
    .qb   (qb)
  );
  // next state: accept only in IDLE, leave CALC once the last step is taken
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? CALC : IDLE) :
              state == CALC ? (cnt == '0 ? FIX : CALC) :
              state == FIX  ? DONE : IDLE;
  end
  // state register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_n;
  // operand capture and iteration; dvd shifts dividend bits out and quotient bits in
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      raw <= '0;
      cnt <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      dbz <= 1'b0;
    end else if (state == IDLE && accept) begin
      dvd <= abs_a;
      dvs <= abs_b;
      rem <= '0;
      raw <= a;
      cnt <= CW'(DATA_W - 1);
      qneg <= a[DATA_W-1] ^ b[DATA_W-1];
      rneg <= a[DATA_W-1];
      dbz <= b == '0;
    end else if (state == CALC) begin
      rem <= rem_n;
      dvd <= {dvd[DATA_W-2:0], qb};
      cnt <= cnt - 1'b1;
    end
  end
  // result register: written in FIX, held until the next result
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata <= '0;
      dbz_out <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= state == FIX;
      if (state == FIX) begin
        m_axis_dout_tdata <= {q_fix, r_fix};
        dbz_out <= dbz;
      end
    end
  end
`ifdef DIVIDER_DBZ_FLAG_EN
  assign m_axis_dout_tuser = dbz_out;
`else
  logic unused_dbz_out;
  assign unused_dbz_out = dbz_out;
`endif
endmodule

// File: tb/tb_axis_int_divider.sv
// tb_axis_int_divider: randomized self-checking bench with a behavioural division model
module tb_axis_int_divider;
  import div_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dvd_v = 1'b0, dvs_v = 1'b0;
  logic [31:0] dvd = '0, dvs = '0;
  logic tvalid;
  logic [63:0] tdata;
  logic tuser;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  axis_int_divider dut (
    .aclk                  (clk),
    .aresetn               (rst_n),
    .s_axis_dividend_tvalid(dvd_v),
    .s_axis_dividend_tdata (dvd),
    .s_axis_divisor_tvalid (dvs_v),
    .s_axis_divisor_tdata  (dvs),
    .m_axis_dout_tvalid    (tvalid),
    .m_axis_dout_tdata     (tdata)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .m_axis_dout_tuser     (tuser)
`endif
  );
`ifndef DIVIDER_DBZ_FLAG_EN
  assign tuser = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {q, r};
  endfunction

  // behavioural model: one division in flight, result visible for one cycle after DIV_LATENCY-1 edges
  bit busy = 0;
  int left = 0;
  logic exp_v = 0, exp_u = 0, pend_u = 0;
  logic [63:0] exp_d = '0, pend = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; left = 0; exp_v = 0; exp_d = '0; exp_u = 0;
    end else if (busy) begin
      left--;
      if (left == 1) begin
        exp_v = 1; exp_d = pend; exp_u = pend_u;
      end else if (left == 0) begin
        exp_v = 0; busy = 0;
      end
    end else if (dvd_v && dvs_v) begin
      busy = 1; left = DIV_LATENCY; pend = ref_div(dvd, dvs); pend_u = (dvs == 0);
    end
  end

  // compare on every falling edge outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tvalid", 64'(tvalid), 64'(exp_v));
      chk("tdata", tdata, exp_d);
`ifdef DIVIDER_DBZ_FLAG_EN
      chk("tuser", 64'(tuser), 64'(exp_u));
`endif
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b, input int pre, output logic [63:0] res);
    int n;
    bit seen;
    @(negedge clk);
    dvd = a; dvs = b; dvd_v = 1; dvs_v = (pre == 0);
    repeat (pre) @(negedge clk);
    dvs_v = 1;
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      if (tvalid) seen = 1;
      else n++;
    end
    chk("latency", 64'(n), 64'(DIV_LATENCY - 1));
    res = tdata;
    @(negedge clk);
    dvd_v = 0; dvs_v = 0;
    @(negedge clk);
  endtask

  logic [63:0] r;
  logic [31:0] ra, rb;
  initial begin
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    op(32'd100, 32'd7, 0, r);
    chk("lit_100_7", r, {32'd14, 32'd2});
    op(-32'sd100, 32'd7, 0, r);
    chk("lit_m100_7", r, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
    op(32'd100, -32'sd7, 0, r);
    chk("lit_100_m7", r, {32'hFFFF_FFF2, 32'd2});
    op(32'd5, 32'd0, 0, r);
    chk("lit_dbz", r, {DBZ_QUOT, 32'd5});
`ifdef DIVIDER_DBZ_FLAG_EN
    chk("lit_dbz_tuser", 64'(tuser), 64'd1);
`endif
    op(INT_MIN, 32'hFFFF_FFFF, 0, r);
    chk("lit_ovf", r, {INT_MIN, 32'd0});
    op(32'd0, 32'd9, 0, r);
    chk("lit_0_9", r, 64'd0);
    op(32'd77, 32'd5, 10, r);
    chk("lit_stagger", r, {32'd15, 32'd2});
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if (i % 6 == 0) ra = INT_MIN;
      op(ra, rb, $urandom_range(0, 3), r);
      chk("rand", r, ref_div(ra, rb));
    end
    @(negedge clk);
    dvd = 32'd1234; dvs = 32'd3; dvd_v = 1; dvs_v = 1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_tvalid", 64'(tvalid), 64'd0);
    chk("abort_tdata", tdata, 64'd0);
    dvd_v = 0; dvs_v = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    op(32'd1000, 32'd10, 0, r);
    chk("lit_after_rst", r, {32'd100, 32'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_int_divider.md
Name: axis_int_divider

Overview:
- Iterative 32-bit signed integer divider with AXI4-Stream-style valid-only channels (no tready).
- Sits behind the CPU's divide functional unit.
- The functional unit holds the dividend and divisor valids high until it sees m_axis_dout_tvalid, then reads the quotient from dout_tdata[63:32].
- One division in flight at a time; fixed latency.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W; dout is 2*DATA_W.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tdata  in  32  dividend, two's complement.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tdata  in  32  divisor, two's complement.
- m_axis_dout_tvalid  out  1  result valid, one-cycle pulse.
- m_axis_dout_tdata  out  64  [63:32] = quotient, [31:0] = remainder.

Behaviour:
- Interface: clock is aclk; reset is aresetn, asynchronous and active-low. Asserting aresetn low immediately forces state IDLE, m_axis_dout_tvalid=0, m_axis_dout_tdata=0 and clears all internal registers.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept occurs on an edge where both tvalids are 1.
  - On accept, latch both operands, record the quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]), take absolute values, load count=31, go to CALC.
  - If only one tvalid is high, nothing is latched and the core keeps waiting. Both channels must be valid in the same cycle.
- CALC:
  - One restoring radix-2 step per edge: shift the partial remainder left with the next dividend bit, subtract the divisor if the result is not negative, shift a quotient bit in.
  - After 32 steps go to FIX.
  - Input tvalid/tdata are ignored in this state.
- FIX:
  - Negate the quotient if its sign is set; negate the remainder if the dividend was negative.
  - Apply the special cases below.
  - Register the result into m_axis_dout_tdata, set m_axis_dout_tvalid=1, go to DONE.
- DONE:
  - m_axis_dout_tvalid is high for exactly this one cycle.
  - Next edge: tvalid=0, go to IDLE.
  - No accept in DONE, so valids still high during the pulse cycle do not start a second division.
- Latency: with the accept edge as edge 0, tvalid rises after edge 33 and falls after edge 34. The next accept is possible at edge 35.
- m_axis_dout_tdata holds its value until the next result is written. Only reset clears it.
- Rounding: quotient truncates toward zero; the remainder takes the sign of the dividend; dividend = q*divisor + r.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Latency is the same 34 edges for every operand pair, including the special cases.
- Reset during CALC/FIX/DONE aborts the operation; no result pulse is produced.

Optional Feature:
- Macro DIVIDER_DBZ_FLAG_EN.
- When defined: adds output m_axis_dout_tuser (1 bit). It is valid with m_axis_dout_tvalid and is 1 if the divisor was zero; it is held like tdata and reset to 0.
- When undefined: the port does not exist; all other behaviour is identical.

Decomposition:
- Package div_pkg holds:
  - DATA_W;
  - the state enum {IDLE, CALC, FIX, DONE};
  - the constants DIV_ITERS=32 and DIV_LATENCY=34;
  - the constants DBZ_QUOT=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
- One sub-module, div_step: a combinational single restoring iteration (partial remainder, divisor, next bit -> new partial remainder, quotient bit), instantiated in the CALC datapath.

Test Plan:
- 100 / 7, valids held until tvalid -> after 34 edges tdata = {32'd14, 32'd2}; tvalid high exactly one cycle; no second result while valids stay high.
- -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). 100 / -7 -> {-14, 2}.
- 5 / 0 -> {0xFFFFFFFF, 5}; tuser=1 with DIVIDER_DBZ_FLAG_EN.
- 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0}. 0 / 9 -> {0, 0}.
- Dividend valid alone for 10 cycles, then divisor valid -> accept only on the first edge where both are high; latency is counted from that edge.
- aresetn low at edge 15 of a division -> tvalid and tdata are 0 immediately, no pulse follows; after release a new 1000/10 returns {100, 0} in 34 edges.
